// File: rtl/display_scan_mux.sv
// Multiplexed 7-segment scanner: captures a packed hex word through a load/ready
// handshake, double-buffers it, and swaps buffers only at the frame boundary.
module display_scan_mux #(
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int BLANK_CYC   = 16,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    output logic                  ready,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_V = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   pend;
    logic [4*DIGITS-1:0]   disp;

    logic                  is_b;
    logic [DIGITS-1:0]     show;
    logic [3:0]            cur_nib;
    logic                  cur_show;
    logic [DIGITS-1:0]     an_next;
    logic [6:0]            seg_next;

    // Segment order {a,b,c,d,e,f,g}, active-high.
    function automatic logic [6:0] hex_font(input logic [3:0] n);
        case (n)
            4'h0:    hex_font = 7'b1111110;
            4'h1:    hex_font = 7'b0110000;
            4'h2:    hex_font = 7'b1101101;
            4'h3:    hex_font = 7'b1111001;
            4'h4:    hex_font = 7'b0110011;
            4'h5:    hex_font = 7'b1011011;
            4'h6:    hex_font = 7'b1011111;
            4'h7:    hex_font = 7'b1110000;
            4'h8:    hex_font = 7'b1111111;
            4'h9:    hex_font = 7'b1111011;
            4'hA:    hex_font = 7'b1110111;
            4'hB:    hex_font = 7'b0011111;
            4'hC:    hex_font = 7'b1001110;
            4'hD:    hex_font = 7'b0111101;
            4'hE:    hex_font = 7'b1001111;
            default: hex_font = 7'b1000111;
        endcase
    endfunction

    assign is_b = (cnt == CNT_MAX) && (idx == IDX_MAX);

    // A digit stays lit once any nibble at or above it is non-zero.
    always_comb begin
        logic nz;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nz       = 1'b0;
        show     = '0;
        cur_nib  = 4'h0;
        cur_show = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nz      = nz | (|disp[4*k +: 4]);
            show[k] = nz || (k == 0) || (LZ_SUPPRESS == 0);
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib  = disp[4*k +: 4];
                cur_show = show[k];
            end
        end
    end

    always_comb begin
        an_next  = '0;
        seg_next = 7'b0000000;
        if ((cnt >= BLANK_V) && cur_show) begin
            an_next  = DIGITS'(1) << idx;
            seg_next = hex_font(cur_nib);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // NOTE: both buffers are reset because a blank-but-defined display after reset is observable behaviour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend  <= '0;
            disp  <= '0;
            ready <= 1'b1;
        end else if (load && ready) begin
            if (is_b) begin
                disp <= value;
            end else begin
                pend  <= value;
                ready <= 1'b0;
            end
        end else if (is_b && !ready) begin
            disp  <= pend;
            ready <= 1'b1;
        end
    end

    // Registered outputs: one cycle behind cnt/idx/disp, so the buffer swap and frame_tick line up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg        <= 7'b0000000;
            an         <= '0;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_next;
            an         <= an_next;
            frame_tick <= is_b;
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, LZ_SUPPRESS=1.
module tb_display_scan_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic        ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int e = 0;  // edges since the latest reset release

    // Expected per-digit fonts and enables for the frame on screen and the next one.
    logic [6:0] cur_seg [4];
    logic [6:0] nxt_seg [4];
    logic [3:0] cur_en;
    logic [3:0] nxt_en;

    localparam logic [6:0] F0 = 7'b1111110;
    localparam logic [6:0] F1 = 7'b0110000;
    localparam logic [6:0] F2 = 7'b1101101;
    localparam logic [6:0] F3 = 7'b1111001;
    localparam logic [6:0] F4 = 7'b0110011;
    localparam logic [6:0] F5 = 7'b1011011;
    localparam logic [6:0] F7 = 7'b1110000;
    localparam logic [6:0] FA = 7'b1110111;
    localparam logic [6:0] FF = 7'b1000111;

    display_scan_mux #(
        .DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .LZ_SUPPRESS(1)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .value(value),
        .ready(ready), .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cur(input logic [6:0] s3, s2, s1, s0, input logic [3:0] en);
        cur_seg[3] = s3; cur_seg[2] = s2; cur_seg[1] = s1; cur_seg[0] = s0; cur_en = en;
    endtask

    task automatic set_next(input logic [6:0] s3, s2, s1, s0, input logic [3:0] en);
        nxt_seg[3] = s3; nxt_seg[2] = s2; nxt_seg[1] = s1; nxt_seg[0] = s0; nxt_en = en;
    endtask

    // One clock edge; outputs after edge e reflect cnt=(e-1)%8, idx=((e-1)/8)%4.
    task automatic step(input logic ld, input logic [15:0] val);
        int c;
        int d;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        load  = ld;
        value = val;
        @(posedge clk);
        #1;
        load = 1'b0;
        e++;
        c = (e - 1) % 8;
        d = ((e - 1) / 8) % 4;
        exp_an  = ((c >= 2) && cur_en[d]) ? (4'b0001 << d) : 4'b0000;
        exp_seg = (exp_an != 4'b0000) ? cur_seg[d] : 7'b0000000;
        check($sformatf("an@%0d", e), 32'(an), 32'(exp_an));
        check($sformatf("seg@%0d", e), 32'(seg), 32'(exp_seg));
        check($sformatf("tick@%0d", e), 32'(frame_tick), 32'((e % 32) == 0));
        if ((e % 32) == 0) begin
            cur_seg = nxt_seg;
            cur_en  = nxt_en;
        end
    endtask

    task automatic run_to(input int target);
        while (e < target) step(1'b0, 16'hBEEF);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"}, 32'(seg), 32'h0);
        check({tag, "_an"}, 32'(an), 32'h0);
        check({tag, "_ready"}, 32'(ready), 32'h1);
        check({tag, "_tick"}, 32'(frame_tick), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        // Reset held with load asserted: nothing is captured, outputs idle.
        reset = 1'b0;
        load  = 1'b1;
        value = 16'h9999;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clk);
        load  = 1'b0;
        reset = 1'b1;
        e = 0;
        set_cur(F0, F0, F0, F0, 4'b0001);
        set_next(F0, F0, F0, F0, 4'b0001);

        // Load at the first edge after reset; pending until the frame boundary.
        step(1'b1, 16'h00A5);
        check("a5_pending", 32'(ready), 32'h0);
        set_next(F0, F0, FA, F5, 4'b0011);
        run_to(31);
        check("a5_still_pending", 32'(ready), 32'h0);
        step(1'b0, 16'h0000);
        check("a5_accepted", 32'(ready), 32'h1);

        // All digits lit, then back to a lone zero.
        run_to(39);
        step(1'b1, 16'hF000);
        check("f000_pending", 32'(ready), 32'h0);
        set_next(FF, F0, F0, F0, 4'b1111);
        run_to(64);
        check("f000_accepted", 32'(ready), 32'h1);
        run_to(69);
        step(1'b1, 16'h0000);
        set_next(F0, F0, F0, F0, 4'b0001);
        run_to(96);

        // Second load while pending is ignored.
        run_to(99);
        step(1'b1, 16'h1234);
        check("1234_pending", 32'(ready), 32'h0);
        set_next(F1, F2, F3, F4, 4'b1111);
        run_to(104);
        step(1'b1, 16'h5678);
        run_to(127);
        check("1234_still_pending", 32'(ready), 32'h0);
        step(1'b0, 16'h0000);
        check("1234_accepted", 32'(ready), 32'h1);

        // Load exactly in the boundary cycle goes straight to the display.
        run_to(159);
        set_next(F0, F0, F0, F7, 4'b0001);
        step(1'b1, 16'h0007);
        check("b_load_ready", 32'(ready), 32'h1);
        run_to(192);

        // Mid-frame reset discards the pending value.
        run_to(194);
        step(1'b1, 16'h9999);
        check("9999_pending", 32'(ready), 32'h0);
        run_to(200);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        e = 0;
        set_cur(F0, F0, F0, F0, 4'b0001);
        set_next(F0, F0, F0, F0, 4'b0001);
        run_to(64);
        check("post_reset_ready", 32'(ready), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
